// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants, stage indices and FSM state codes for the pipeline controller.
package pipeline_ctrl_pkg;

  localparam int unsigned STALL_W = 6;

  localparam int unsigned STG_PC  = 0;
  localparam int unsigned STG_IF  = 1;
  localparam int unsigned STG_ID  = 2;
  localparam int unsigned STG_EX  = 3;
  localparam int unsigned STG_MEM = 4;
  localparam int unsigned STG_WB  = 5;

  typedef enum logic [1:0] {
    CtrlIdle  = 2'd0,
    CtrlPend  = 2'd1,
    CtrlRedir = 2'd2
  } ctrl_state_e;

  // Stall vector that holds every stage from PC up to and including 'top'.
  function automatic logic [STALL_W-1:0] stall_upto(input int unsigned top);
    logic [STALL_W-1:0] m;
    for (int unsigned k = 0; k < STALL_W; k++) begin
      m[k] = (k <= top);
    end
    return m;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_perf_counter.sv
// Event counter with synchronous active-low clear and enable; wraps or saturates.
module pipeline_ctrl_perf_counter #(
  parameter int unsigned Width    = 32,
  parameter bit          Saturate = 1'b0
) (
  input  logic             clk_in,
  input  logic             clr_n,
  input  logic             en,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk_in) begin
    if (!clr_n) begin
      count_q <= '0;
    end else if (en && !(Saturate && (count_q == '1))) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall arbiter and branch redirect sequencer with stall/flush performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned FLUSH_W = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               stallreq_if_in,
  input  logic               stallreq_id_in,
  input  logic               stallreq_mem_in,
  input  logic               branch_in,
  input  logic [31:0]        branch_target_in,
  input  logic               redirect_ack_in,
  output logic [STALL_W-1:0] stall_out,
  output logic               branch_or_not,
  output logic               redirect_valid_out,
  output logic [31:0]        redirect_pc_out,
  output logic [CNT_W-1:0]   stall_cycles_out,
  output logic [FLUSH_W-1:0] flush_count_out
);

  ctrl_state_e state_q, state_d;
  logic [31:0] tgt_q, tgt_d;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= CtrlIdle;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tgt_d         = tgt_q;
    branch_or_not = 1'b0;
    if (rdy_in) begin
      // Latest branch target always wins, whatever the state.
      if (branch_in) begin
        tgt_d = branch_target_in;
      end
      case (state_q)
        CtrlIdle: begin
          if (branch_in) begin
            if (stallreq_mem_in) begin
              state_d = CtrlPend;
            end else begin
              state_d       = CtrlRedir;
              branch_or_not = 1'b1;
            end
          end
        end
        CtrlPend: begin
          if (!stallreq_mem_in) begin
            state_d       = CtrlRedir;
            branch_or_not = 1'b1;
          end
        end
        CtrlRedir: begin
          // A fresh target arriving with the ack keeps the redirect open for it.
          if (redirect_ack_in && !branch_in) begin
            state_d = CtrlIdle;
          end
        end
        default: state_d = CtrlIdle;
      endcase
    end
    if (!rst_in) begin
      branch_or_not = 1'b0;
    end
  end

  always_comb begin
    stall_out = '0;
    if (rst_in) begin
      if (stallreq_mem_in) begin
        stall_out = stall_upto(STG_MEM);
      end else if (stallreq_id_in) begin
        stall_out = stall_upto(STG_ID);
      end else if (stallreq_if_in || (state_q == CtrlRedir)) begin
        stall_out = stall_upto(STG_IF);
      end
    end
  end

  assign redirect_valid_out = (state_q == CtrlRedir);
  assign redirect_pc_out    = redirect_valid_out ? tgt_q : '0;

  pipeline_ctrl_perf_counter #(
    .Width    (CNT_W),
    .Saturate (1'b0)
  ) u_stall_cnt (
    .clk_in (clk_in),
    .clr_n  (rst_in),
    .en     (rdy_in && (stall_out != '0)),
    .count  (stall_cycles_out)
  );

  pipeline_ctrl_perf_counter #(
    .Width    (FLUSH_W),
    .Saturate (1'b1)
  ) u_flush_cnt (
    .clk_in (clk_in),
    .clr_n  (rst_in),
    .en     (branch_or_not),
    .count  (flush_count_out)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and randomized bench for pipeline_ctrl against a behavioural redirect model.
module tb_pipeline_ctrl;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned FLUSH_W = 4;

  logic               clk = 1'b0;
  logic               rst_n, rdy, req_if, req_id, req_mem, branch, ack;
  logic [31:0]        target;
  logic [5:0]         stall;
  logic               bon, rvalid;
  logic [31:0]        rpc;
  logic [CNT_W-1:0]   scnt;
  logic [FLUSH_W-1:0] fcnt;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  pipeline_ctrl #(
    .CNT_W   (CNT_W),
    .FLUSH_W (FLUSH_W)
  ) dut (
    .clk_in             (clk),
    .rst_in             (rst_n),
    .rdy_in             (rdy),
    .stallreq_if_in     (req_if),
    .stallreq_id_in     (req_id),
    .stallreq_mem_in    (req_mem),
    .branch_in          (branch),
    .branch_target_in   (target),
    .redirect_ack_in    (ack),
    .stall_out          (stall),
    .branch_or_not      (bon),
    .redirect_valid_out (rvalid),
    .redirect_pc_out    (rpc),
    .stall_cycles_out   (scnt),
    .flush_count_out    (fcnt)
  );

  always #5 clk = ~clk;

  // Model: a branch is either parked behind a MEM stall or an outstanding redirect.
  bit                 m_parked = 1'b0;
  bit                 m_redir  = 1'b0;
  logic [31:0]        m_tgt    = '0;
  logic [CNT_W-1:0]   m_scnt   = '0;
  logic [FLUSH_W-1:0] m_fcnt   = '0;

  function automatic logic [5:0] exp_stall();
    if (!rst_n)       return 6'b000000;
    if (req_mem)      return 6'b011111;
    if (req_id)       return 6'b000111;
    if (req_if || m_redir) return 6'b000011;
    return 6'b000000;
  endfunction

  function automatic bit exp_flush();
    if (!rst_n || !rdy || req_mem) return 1'b0;
    return m_parked || (branch && !m_redir);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit f;
    if (!rst_n) begin
      m_parked <= 1'b0;
      m_redir  <= 1'b0;
      m_tgt    <= '0;
      m_scnt   <= '0;
      m_fcnt   <= '0;
    end else if (rdy) begin
      f = exp_flush();
      if (exp_stall() != 6'd0) m_scnt <= m_scnt + 1'b1;
      if (branch) m_tgt <= target;
      if (f) begin
        m_parked <= 1'b0;
        m_redir  <= 1'b1;
        if (m_fcnt != {FLUSH_W{1'b1}}) m_fcnt <= m_fcnt + 1'b1;
      end else if (branch && !m_parked && !m_redir) begin
        m_parked <= 1'b1;
      end else if (m_redir && ack && !branch) begin
        m_redir <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_stall", 32'(stall), 32'(exp_stall()));
      check("model_flush", 32'(bon), 32'(exp_flush()));
      check("model_rvalid", 32'(rvalid), 32'(m_redir));
      if (m_redir) check("model_rpc", rpc, m_tgt);
      check("model_stall_cnt", 32'(scnt), 32'(m_scnt));
      check("model_flush_cnt", 32'(fcnt), 32'(m_fcnt));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; req_if = 1'b0; req_id = 1'b0; req_mem = 1'b0;
    branch = 1'b0; ack = 1'b0; target = '0;
    cyc();
    cyc();
    chk_en = 1'b1;
    settle();
    check("reset_stall", 32'(stall), 32'h0);
    check("reset_rvalid", 32'(rvalid), 32'h0);
    check("reset_scnt", 32'(scnt), 32'h0);
    check("reset_fcnt", 32'(fcnt), 32'h0);

    // ID hazard alone
    rst_n = 1'b1; req_id = 1'b1;
    settle();
    check("id_stall", 32'(stall), 32'h07);
    check("id_bon", 32'(bon), 32'h0);
    cyc();
    check("id_scnt1", 32'(scnt), 32'd1);
    cyc();
    check("id_scnt2", 32'(scnt), 32'd2);
    req_id = 1'b0;

    // MEM outranks IF
    req_if = 1'b1; req_mem = 1'b1;
    settle();
    check("mem_wins", 32'(stall), 32'h1F);
    cyc();
    req_if = 1'b0; req_mem = 1'b0;

    // Plain branch
    branch = 1'b1; target = 32'h0000_1040;
    settle();
    check("br_bon", 32'(bon), 32'h1);
    cyc();
    branch = 1'b0;
    settle();
    check("br_rvalid", 32'(rvalid), 32'h1);
    check("br_rpc", rpc, 32'h0000_1040);
    check("br_stall", 32'(stall), 32'h03);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    settle();
    check("br_idle", 32'(rvalid), 32'h0);
    check("br_fcnt", 32'(fcnt), 32'd1);

    // Branch parked behind a 3-cycle MEM stall
    req_mem = 1'b1; branch = 1'b1; target = 32'h0000_2000;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("park_bon_low", 32'(bon), 32'h0);
      cyc();
      branch = 1'b0;
    end
    req_mem = 1'b0;
    settle();
    check("park_bon_high", 32'(bon), 32'h1);
    cyc();
    settle();
    check("park_rpc", rpc, 32'h0000_2000);
    ack = 1'b1;
    cyc();
    ack = 1'b0;

    // Reset while a branch is parked
    req_mem = 1'b1; branch = 1'b1; target = 32'h0000_5555;
    cyc();
    branch = 1'b0; rst_n = 1'b0;
    settle();
    check("rst_stall_zero", 32'(stall), 32'h0);
    cyc();
    rst_n = 1'b1; req_mem = 1'b0;
    settle();
    check("rst_no_flush", 32'(bon), 32'h0);
    check("rst_scnt", 32'(scnt), 32'h0);
    check("rst_fcnt", 32'(fcnt), 32'h0);
    cyc();
    settle();
    check("rst_no_late_flush", 32'(bon), 32'h0);

    // rdy low in REDIR with ack held
    branch = 1'b1; target = 32'h0000_3000;
    cyc();
    branch = 1'b0; rdy = 1'b0; ack = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    settle();
    check("frz_rvalid", 32'(rvalid), 32'h1);
    check("frz_rpc", rpc, 32'h0000_3000);
    check("frz_bon", 32'(bon), 32'h0);
    check("frz_scnt", 32'(scnt), 32'h0);
    check("frz_fcnt", 32'(fcnt), 32'd1);
    rdy = 1'b1;
    cyc();
    ack = 1'b0;
    settle();
    check("thaw_idle", 32'(rvalid), 32'h0);
    check("thaw_scnt", 32'(scnt), 32'd1);

    // Flush counter saturation
    for (int i = 0; i < 20; i++) begin
      branch = 1'b1; target = 32'(i);
      cyc();
      branch = 1'b0; ack = 1'b1;
      cyc();
      ack = 1'b0;
    end
    settle();
    check("flush_sat", 32'(fcnt), 32'hF);
    check("sat_scnt", 32'(scnt), 32'd21);

    // Randomized traffic, checked against the model every cycle
    for (int i = 0; i < 4000; i++) begin
      rst_n  = ($urandom_range(0, 199) != 0);
      rdy    = ($urandom_range(0, 9) != 0);
      req_if = ($urandom_range(0, 3) == 0);
      req_id = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) req_mem = ~req_mem;
      branch = ($urandom_range(0, 3) == 0);
      target = $urandom;
      ack    = ($urandom_range(0, 2) == 0);
      cyc();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
